fft_sdf_bfly2: RTL and testbench

- Radix-2 decimation-in-frequency butterfly stage, single-path delay-feedback (SDF) style, for the streaming FFT pipeline.
- Sits directly upstream of the 0.7071 twiddle multiplier stage.
- Consumes one complex sample per enabled cycle.
- Emits butterfly sums, then butterfly differences, with per-sample twiddle hints (DS, MPYJ, TW_IDX) that drive the downstream rotator.

---
 rtl/fft_sdf_bfly2_if.sv | 28 ++
 rtl/fft_sdf_bfly2.sv | 117 +++++++++++
 tb/tb_fft_sdf_bfly2.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fft_sdf_bfly2_if.sv
// Streaming port bundle for the radix-2 SDF butterfly stage: sample input side
// plus result/twiddle-hint output side.
interface fft_sdf_bfly2_if #(
    parameter int total_bits = 16,
    parameter int LOG_N      = 3
);
    logic                         ed;
    logic                         start;
    logic signed [total_bits-1:0] dr;
    logic signed [total_bits-1:0] di;
    logic signed [total_bits:0]   dor;
    logic signed [total_bits:0]   doi;
    logic                         valid;
    logic                         rdy;
    logic                         ds;
    logic                         mpyj;
    logic [LOG_N-2:0]             tw_idx;

    modport master (
        output ed, start, dr, di,
        input  dor, doi, valid, rdy, ds, mpyj, tw_idx
    );

    modport slave (
        input  ed, start, dr, di,
        output dor, doi, valid, rdy, ds, mpyj, tw_idx
    );
endinterface

// File: rtl/fft_sdf_bfly2.sv
// Radix-2 DIF butterfly, single-path delay feedback: sums leave in phase B, differences
// are parked in the N/2 delay line and leave during the next frame's phase A.
module fft_sdf_bfly2 #(
    parameter int total_bits = 16,
    parameter int LOG_N      = 3
) (
    input logic             clk,
    input logic             rst,
    fft_sdf_bfly2_if.slave  bus
);
    localparam int N    = 1 << LOG_N;
    localparam int HALF = N / 2;
    localparam int W    = total_bits + 1;
    localparam logic [LOG_N-1:0] CntHalf = LOG_N'(HALF);
    localparam logic [LOG_N-1:0] CntLast = LOG_N'(N - 1);

    logic [LOG_N-1:0] cnt_q, cnt_d, cnt_eff;
    logic             run_q;
    logic             dvalid_q, dvalid_d;
    logic             adv, phase_b;

    logic signed [W-1:0] in_re, in_im, pop_re, pop_im, push_re, push_im;
    logic signed [W-1:0] dor_q, doi_q, dor_d, doi_d;
    logic                valid_q, valid_d, rdy_q, rdy_d, ds_q, ds_d, mpyj_q, mpyj_d;
    logic [LOG_N-2:0]    tw_q, tw_d;

    logic signed [W-1:0] dl_re [HALF];
    logic signed [W-1:0] dl_im [HALF];

    always_comb begin
        // A START sample is processed as index 0 of a fresh frame.
        cnt_eff = bus.start ? '0 : cnt_q;
        adv     = bus.ed & (bus.start | run_q);
        phase_b = cnt_eff[LOG_N-1];
        cnt_d   = cnt_eff + LOG_N'(1);

        in_re  = {bus.dr[total_bits-1], bus.dr};
        in_im  = {bus.di[total_bits-1], bus.di};
        pop_re = dl_re[HALF-1];
        pop_im = dl_im[HALF-1];

        dvalid_d = bus.start ? 1'b0 : dvalid_q;
        dor_d    = pop_re;
        doi_d    = pop_im;
        push_re  = in_re;
        push_im  = in_im;
        valid_d  = 1'b0;
        rdy_d    = 1'b0;
        ds_d     = 1'b0;
        mpyj_d   = 1'b0;
        tw_d     = '0;

        if (phase_b) begin
            dor_d   = pop_re + in_re;
            doi_d   = pop_im + in_im;
            push_re = pop_re - in_re;
            push_im = pop_im - in_im;
            valid_d = 1'b1;
            rdy_d   = (cnt_eff == CntHalf);
            if (cnt_eff == CntLast) begin
                dvalid_d = 1'b1;
            end
        end else begin
            // Differences of a frame aborted by START are flagged invalid here.
            valid_d = dvalid_d;
            tw_d    = cnt_eff[LOG_N-2:0];
            ds_d    = dvalid_d & cnt_eff[0];
            mpyj_d  = dvalid_d & cnt_eff[LOG_N-2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            run_q    <= 1'b0;
            dvalid_q <= 1'b0;
            dor_q    <= '0;
            doi_q    <= '0;
            valid_q  <= 1'b0;
            rdy_q    <= 1'b0;
            ds_q     <= 1'b0;
            mpyj_q   <= 1'b0;
            tw_q     <= '0;
        end else if (adv) begin
            cnt_q    <= cnt_d;
            run_q    <= 1'b1;
            dvalid_q <= dvalid_d;
            dor_q    <= dor_d;
            doi_q    <= doi_d;
            valid_q  <= valid_d;
            rdy_q    <= rdy_d;
            ds_q     <= ds_d;
            mpyj_q   <= mpyj_d;
            tw_q     <= tw_d;
        end
    end

    // Delay line needs no reset: entries are only observed once rewritten.
    always_ff @(posedge clk) begin
        if (adv) begin
            dl_re[0] <= push_re;
            dl_im[0] <= push_im;
            for (int i = 1; i < HALF; i++) begin
                dl_re[i] <= dl_re[i-1];
                dl_im[i] <= dl_im[i-1];
            end
        end
    end

    assign bus.dor    = dor_q;
    assign bus.doi    = doi_q;
    assign bus.valid  = valid_q;
    assign bus.rdy    = rdy_q;
    assign bus.ds     = ds_q;
    assign bus.mpyj   = mpyj_q;
    assign bus.tw_idx = tw_q;
endmodule

// File: tb/tb_fft_sdf_bfly2.sv
// Bench for fft_sdf_bfly2: directed scenarios plus random streams, all checked against
// a frame-level butterfly model held in arrays.
module tb_fft_sdf_bfly2;
    localparam int TB  = 16;
    localparam int LN  = 3;
    localparam int N   = 1 << LN;
    localparam int HALF = N / 2;

    logic clk;
    logic rst;

    fft_sdf_bfly2_if #(.total_bits(TB), .LOG_N(LN)) bus ();

    fft_sdf_bfly2 #(.total_bits(TB), .LOG_N(LN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: samples of the current frame, differences of the last one.
    bit m_run;
    bit m_dvalid;
    int m_idx;
    int m_x_re [N];
    int m_x_im [N];
    int m_d_re [HALF];
    int m_d_im [HALF];
    int e_dor, e_doi, e_tw;
    bit e_valid, e_rdy, e_ds, e_mpyj;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_dvalid = 0; m_idx = 0;
        e_dor = 0; e_doi = 0; e_tw = 0;
        e_valid = 0; e_rdy = 0; e_ds = 0; e_mpyj = 0;
    endtask

    task automatic model_step(input bit ed, input bit start, input int dr, input int di);
        int k;
        int j;
        if (!ed || !(start || m_run)) return;
        if (start) begin
            m_run = 1; m_idx = 0; m_dvalid = 0;
        end
        k = m_idx;
        if (k < HALF) begin
            e_dor   = m_d_re[k];
            e_doi   = m_d_im[k];
            m_x_re[k] = dr;
            m_x_im[k] = di;
            e_valid = m_dvalid;
            e_tw    = k;
            e_ds    = m_dvalid && (k % 2 == 1);
            e_mpyj  = m_dvalid && (k >= HALF / 2);
            e_rdy   = 0;
        end else begin
            j = k - HALF;
            e_dor   = m_x_re[j] + dr;
            e_doi   = m_x_im[j] + di;
            m_d_re[j] = m_x_re[j] - dr;
            m_d_im[j] = m_x_im[j] - di;
            e_valid = 1;
            e_tw    = 0;
            e_ds    = 0;
            e_mpyj  = 0;
            e_rdy   = (k == HALF);
            if (k == N - 1) m_dvalid = 1;
        end
        m_idx = (k + 1) % N;
    endtask

    task automatic compare_all(input string tag);
        check_eq({tag, "_valid"}, longint'(bus.valid), longint'(e_valid));
        check_eq({tag, "_rdy"}, longint'(bus.rdy), longint'(e_rdy));
        check_eq({tag, "_ds"}, longint'(bus.ds), longint'(e_ds));
        check_eq({tag, "_mpyj"}, longint'(bus.mpyj), longint'(e_mpyj));
        check_eq({tag, "_tw"}, longint'(bus.tw_idx), longint'(e_tw));
        if (e_valid || !m_run) begin
            check_eq({tag, "_dor"}, longint'(bus.dor), longint'(e_dor));
            check_eq({tag, "_doi"}, longint'(bus.doi), longint'(e_doi));
        end
    endtask

    task automatic cycle(input string tag, input bit ed, input bit start, input int dr,
                         input int di);
        bus.ed    = ed;
        bus.start = start;
        bus.dr    = dr[TB-1:0];
        bus.di    = di[TB-1:0];
        @(posedge clk);
        model_step(ed, start, dr, di);
        #1;
        compare_all(tag);
    endtask

    initial begin
        int rdy_cnt;
        int v;
        rst = 1'b1;
        bus.ed = 1'b0; bus.start = 1'b0; bus.dr = '0; bus.di = '0;
        model_reset();
        for (int i = 0; i < N; i++) begin
            m_x_re[i] = 0; m_x_im[i] = 0;
        end
        for (int i = 0; i < HALF; i++) begin
            m_d_re[i] = 0; m_d_im[i] = 0;
        end
        #12;
        compare_all("reset");
        rst = 1'b0;
        cycle("idle", 1'b1, 1'b0, 77, -5);

        // 1: ramp 1..8 then zeros
        for (int i = 0; i < 16; i++) begin
            cycle("t1", 1'b1, i == 0, (i < N) ? i + 1 : 0, 0);
            if (i >= 4 && i <= 7) check_eq("t1_sum", longint'(bus.dor), 2 * i - 2);
            if (i >= 8 && i <= 11) check_eq("t1_diff", longint'(bus.dor), -4);
        end

        // 2: full-scale growth
        for (int i = 0; i < 20; i++) begin
            v = (i < N) ? 32767 : (i < N + HALF) ? -32768 : (i < 2 * N) ? 32767 : 0;
            cycle("t2", 1'b1, i == 0, v, v);
            if (i >= 4 && i <= 7) check_eq("t2_sum", longint'(bus.doi), 65534);
            if (i >= 16 && i <= 19) check_eq("t2_diff", longint'(bus.dor), -65535);
        end

        // 3: ED toggling
        rdy_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            cycle("t3", i % 2 == 0, i == 0, (i / 2 < N) ? i / 2 + 1 : 0, 0);
            if (i % 2 == 0 && i < 24 && bus.rdy) rdy_cnt++;
        end
        check_eq("t3_rdy_count", rdy_cnt, 1);

        // 4: back-to-back frames, one START
        for (int i = 0; i < 2 * N + HALF; i++) begin
            cycle("t4", 1'b1, i == 0, (i < N) ? i + 1 : (i < 2 * N) ? i + 3 : 0, i);
            if (i >= 8 && i <= 11) check_eq("t4_diff", longint'(bus.dor), -4);
            if (i >= 12 && i <= 15) check_eq("t4_sum", longint'(bus.dor), 2 * (i - 12) + 26);
        end

        // 5: START at index 5 aborts the frame
        for (int i = 0; i < 5; i++) cycle("t5a", 1'b1, i == 0, i + 1, -i);
        for (int i = 0; i < N + HALF; i++) begin
            cycle("t5b", 1'b1, i == 0, (i < N) ? i + 1 : 0, 2 * i);
            if (i < HALF) check_eq("t5_valid", longint'(bus.valid), 0);
        end

        // 6: asynchronous reset in phase B
        for (int i = 0; i < 6; i++) cycle("t6a", 1'b1, i == 0, 100 + i, 3 * i);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("t6_async");
        check_eq("t6_async_dor", longint'(bus.dor), 0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) cycle("t6_norun", 1'b1, 1'b0, 55, 55);
        for (int i = 0; i < N + HALF; i++) cycle("t6b", 1'b1, i == 0, i * 7 - 20, 9 - i);

        // random streams
        cycle("rnd_start", 1'b1, 1'b1, 0, 0);
        for (int i = 0; i < 800; i++) begin
            cycle("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0,
                  int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
